// File: rtl/spi_rx_checker.sv
// SPI mode-0 slave receiver: deserializes 32-bit words into a show-ahead FIFO,
// checks that consecutive words count up by one, and throttles the sender.
module spi_rx_checker #(
    parameter int FIFO_DEPTH   = 16,
    parameter int BLOCK_THRESH = 12,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_sck,
    input  logic                          spi_mosi,
    input  logic                          spi_ss_n,
    output logic                          spi_block,
    output logic [31:0]                   rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              seq_err_cnt,
    output logic [CNT_W-1:0]              abort_cnt,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]    THR_LVL  = LW'(BLOCK_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PUSH
    } state_t;

    // Synchronizers; sck carries one extra stage for edge detection
    logic [2:0] sck_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] ss_sync_q;

    logic sck_s;
    logic sck_rise;
    logic mosi_s;
    logic ss_s;

    state_t      state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        push;
    logic        abort_inc;

    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [31:0]    rx_data_q, rx_data_d;
    logic           pop;
    logic           full;
    logic           wr_ok;
    logic           drop;

    logic             seq_init_q, seq_init_d;
    logic [31:0]      exp_q, exp_d;
    logic [CNT_W-1:0] seq_err_q, seq_err_d;
    logic [CNT_W-1:0] abort_q, abort_d;
    logic             ovf_q, ovf_d;
    logic             block_q, block_d;

    assign sck_s    = sck_sync_q[1];
    assign sck_rise = sck_s & ~sck_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];
    assign ss_s     = ss_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
            ss_sync_q   <= 2'b11;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[0], spi_ss_n};
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        abort_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bitcnt_d = '0;
                if (!ss_s) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ss_s) begin
                    state_d   = S_IDLE;
                    bitcnt_d  = '0;
                    abort_inc = (bitcnt_q != 5'd0);
                end else if (sck_rise) begin
                    shreg_d = {shreg_q[30:0], mosi_s};
                    if (bitcnt_q == 5'd31) begin
                        bitcnt_d = '0;
                        state_d  = S_PUSH;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = ss_s ? S_IDLE : S_SHIFT;
                // A rising edge here already belongs to the next word
                if (!ss_s && sck_rise) begin
                    shreg_d  = {shreg_q[30:0], mosi_s};
                    bitcnt_d = 5'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                bitcnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pop      = (level_q != '0) && rx_ready;
        full     = (level_q == FULL_LVL);
        wr_ok    = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_ok && pop) begin
            level_d = level_q - LW'(1);
        end
        // New head bypasses the memory when it is the word being written
        if (level_d == '0) begin
            rx_data_d = rx_data_q;
        end else if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
            rx_data_d = shreg_q;
        end else begin
            rx_data_d = mem_q[rd_ptr_d];
        end
    end

    always_comb begin
        seq_init_d = seq_init_q;
        exp_d      = exp_q;
        seq_err_d  = seq_err_q;
        abort_d    = abort_q;
        ovf_d      = ovf_q | drop;
        block_d    = (level_q >= THR_LVL);
        if (push) begin
            seq_init_d = 1'b1;
            exp_d      = shreg_q + 32'd1;
            if (seq_init_q && (shreg_q != exp_q) && (seq_err_q != CNT_MAX)) begin
                seq_err_d = seq_err_q + CNT_W'(1);
            end
        end
        if (abort_inc && (abort_q != CNT_MAX)) begin
            abort_d = abort_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_data_q  <= '0;
            seq_init_q <= 1'b0;
            exp_q      <= '0;
            seq_err_q  <= '0;
            abort_q    <= '0;
            ovf_q      <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_data_q  <= rx_data_d;
            seq_init_q <= seq_init_d;
            exp_q      <= exp_d;
            seq_err_q  <= seq_err_d;
            abort_q    <= abort_d;
            ovf_q      <= ovf_d;
            block_q    <= block_d;
        end
    end

    assign spi_block   = block_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = (level_q != '0);
    assign fifo_level  = level_q;
    assign seq_err_cnt = seq_err_q;
    assign abort_cnt   = abort_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_spi_rx_checker.sv
// Bench for spi_rx_checker: directed scenarios plus a randomized phase,
// all checked against a queue-based model of delivered words and counters.
module tb_spi_rx_checker;

    localparam int DEPTH  = 16;
    localparam int THRESH = 12;
    localparam int CW     = 16;
    localparam int H      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_ss_n = 1'b1;
    logic        rx_ready = 1'b0;
    logic        spi_block;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [4:0]  fifo_level;
    logic [CW-1:0] seq_err_cnt;
    logic [CW-1:0] abort_cnt;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] exp_q [$];
    bit          m_init;
    logic [31:0] m_exp;
    int          m_err;
    int          m_abort;
    bit          m_ovf;

    spi_rx_checker #(
        .FIFO_DEPTH  (DEPTH),
        .BLOCK_THRESH(THRESH),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_ss_n   (spi_ss_n),
        .spi_block  (spi_block),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .seq_err_cnt(seq_err_cnt),
        .abort_cnt  (abort_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Every pop the DUT performs must match the oldest word the model expects
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("rx_data", 64'(rx_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        repeat (H) tick();
        spi_sck = 1'b1;
        repeat (H) tick();
        spi_sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
        if (m_init && (w != m_exp)) m_err++;
        m_init = 1'b1;
        m_exp  = w + 32'd1;
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic frame_start();
        spi_ss_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_end();
        repeat (4) tick();
        spi_ss_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
        if (n != 0) m_abort++;
        frame_end();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_init  = 1'b0;
        m_exp   = '0;
        m_err   = 0;
        m_abort = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_block"}, 64'(spi_block), 64'd0);
        check({tag, "_data"}, 64'(rx_data), 64'd0);
        check({tag, "_valid"}, 64'(rx_valid), 64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_seq"}, 64'(seq_err_cnt), 64'd0);
        check({tag, "_abort"}, 64'(abort_cnt), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || fifo_level != 0); i++)
            tick();
        repeat (2) tick();
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_seq"}, 64'(seq_err_cnt), 64'(m_err));
        check({tag, "_abort"}, 64'(abort_cnt), 64'(m_abort));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    logic [31:0] seq_words [5];
    logic [31:0] wrap_words [3];
    logic [31:0] last_w;
    logic [31:0] w;

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");

        // Single word latency: N+1 write, N+2 visible, popped next cycle
        rx_ready = 1'b1;
        frame_start();
        send_word(32'h0000_0005);
        check("t1_valid_n1", 64'(rx_valid), 64'd0);
        tick();
        check("t1_valid_n2", 64'(rx_valid), 64'd1);
        check("t1_data_n2", 64'(rx_data), 64'h5);
        tick();
        check("t1_valid_n3", 64'(rx_valid), 64'd0);
        check("t1_level_n3", 64'(fifo_level), 64'd0);
        frame_end();
        check("t1_seq", 64'(seq_err_cnt), 64'd0);

        // Sequence error in a multi-word frame
        do_reset();
        seq_words = '{32'd1, 32'd2, 32'd3, 32'd7, 32'd8};
        rx_ready = 1'b1;
        frame_start();
        foreach (seq_words[i]) send_word(seq_words[i]);
        frame_end();
        drain("t2");
        check("t2_seq_one", 64'(seq_err_cnt), 64'd1);
        check_counters("t2");

        // Wrap-around of the expected value
        do_reset();
        wrap_words = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        frame_start();
        foreach (wrap_words[i]) send_word(wrap_words[i]);
        frame_end();
        drain("t3");
        check("t3_seq_zero", 64'(seq_err_cnt), 64'd0);

        // Abort after 17 bits, then a clean word
        do_reset();
        rx_ready = 1'b1;
        frame_start();
        partial(17);
        frame_start();
        send_word(32'h0000_000A);
        frame_end();
        drain("t4");
        check("t4_abort_one", 64'(abort_cnt), 64'd1);
        check_counters("t4");

        // Back-pressure, spi_block, overflow and drain
        do_reset();
        rx_ready = 1'b0;
        frame_start();
        for (int i = 1; i <= 12; i++) send_word(32'(i));
        tick();
        check("t5_level12", 64'(fifo_level), 64'd12);
        check("t5_block_lag", 64'(spi_block), 64'd0);
        tick();
        check("t5_block_on", 64'(spi_block), 64'd1);
        for (int i = 13; i <= 16; i++) send_word(32'(i));
        tick();
        check("t5_level16", 64'(fifo_level), 64'd16);
        check("t5_ovf_pre", 64'(overflow), 64'd0);
        send_word(32'd17);
        tick();
        check("t5_level_full", 64'(fifo_level), 64'd16);
        check("t5_ovf", 64'(overflow), 64'd1);
        check("t5_seq", 64'(seq_err_cnt), 64'd0);
        frame_end();
        rx_ready = 1'b1;
        for (int i = 0; i < 100 && fifo_level != 5'd11; i++) tick();
        check("t5_level11", 64'(fifo_level), 64'd11);
        check("t5_block_hold", 64'(spi_block), 64'd1);
        tick();
        check("t5_block_off", 64'(spi_block), 64'd0);
        drain("t5");
        check_counters("t5");

        // Reset in the middle of a word
        rx_ready = 1'b1;
        frame_start();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        do_reset();
        check_zero("t6");
        frame_end();
        check("t6_abort", 64'(abort_cnt), 64'd0);
        frame_start();
        send_word(32'h1234_5678);
        frame_end();
        drain("t6");
        check_counters("t6");

        // Randomized frames with mostly consecutive words
        do_reset();
        rand_rdy = 1'b1;
        last_w = $urandom;
        for (int f = 0; f < 12; f++) begin
            frame_start();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                if ($urandom_range(0, 3) == 0) w = $urandom;
                else w = last_w + 32'd1;
                last_w = w;
                send_word(w);
            end
            if ($urandom_range(0, 3) == 0) partial(int'($urandom_range(1, 31)));
            else frame_end();
        end
        rand_rdy = 1'b0;
        drain("rnd");
        check_counters("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
